prio_arb_enc: RTL and testbench

Parametrised, registered priority encoder/arbiter for N request lines, the clocked successor to the 8-to-3 combinational encoder. Captures request pulses into a sticky pending register and selects one pending channel, either fixed priority (highest index wins) or round-robin. It presents the winner as a binary index plus one-hot on a valid/ready output port, holding it stable until accepted. Used wherever several board inputs (keys, switches, event strobes) must be serialised into one indexed event stream.

---
 rtl/prio_arb_if.sv | 28 ++
 rtl/prio_arb_enc.sv | 122 ++++++++++++
 tb/tb_prio_arb_enc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/prio_arb_if.sv
// Request/grant bundle for prio_arb_enc: request strobes in, one indexed grant out.
// Handshake: a grant transfers on any rising edge where out_valid && out_ready; while
// out_valid is high without out_ready, out_idx/out_onehot stay frozen.
interface prio_arb_if #(
   parameter int N = 8
);
   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0] req;
   logic         mode;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic [W:0]   pend_cnt;
   logic         any;
   logic         dbg_state;

   modport slave (
      input  req, mode, out_ready,
      output out_valid, out_idx, out_onehot, pend_cnt, any, dbg_state
   );

   modport master (
      output req, mode, out_ready,
      input  out_valid, out_idx, out_onehot, pend_cnt, any, dbg_state
   );
endinterface

// File: rtl/prio_arb_enc.sv
// Registered priority encoder / arbiter: sticky pending bits, fixed or round-robin
// selection, one grant at a time presented on a valid/ready port.
module prio_arb_enc #(
   parameter int N = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   prio_arb_if.slave   bus
);
   localparam int W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {S_IDLE, S_GRANT} state_e;

   state_e       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic         mode_q, mode_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_idx_q, out_idx_d;
   logic [N-1:0] out_onehot_q, out_onehot_d;

   logic [W-1:0] fix_idx;
   logic [W-1:0] rr_idx;
   logic         rr_found;
   logic [W-1:0] win_idx;
   logic [N-1:0] clr;
   logic [W:0]   cnt;

   // Fixed priority: the last set bit seen on an upward scan is the highest index.
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (pend_q[i]) fix_idx = W'(i);
      end
   end

   // Round-robin: first set bit at or above ptr, wrapping at N (not 2^W).
   always_comb begin
      rr_idx   = '0;
      rr_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (!rr_found && pend_q[j]) begin
            rr_found = 1'b1;
            rr_idx   = W'(j);
         end
      end
   end

   assign win_idx = bus.mode ? rr_idx : fix_idx;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      mode_d       = mode_q;
      out_valid_d  = out_valid_q;
      out_idx_d    = out_idx_q;
      out_onehot_d = out_onehot_q;
      clr          = '0;
      case (state_q)
         S_IDLE: begin
            if (pend_q != '0) begin
               out_idx_d    = win_idx;
               out_onehot_d = N'(1) << win_idx;
               out_valid_d  = 1'b1;
               mode_d       = bus.mode;
               state_d      = S_GRANT;
            end
         end
         S_GRANT: begin
            if (out_valid_q && bus.out_ready) begin
               clr          = out_onehot_q;
               out_valid_d  = 1'b0;
               out_onehot_d = '0;
               state_d      = S_IDLE;
               if (mode_q) begin
                  ptr_d = (out_idx_q == W'(N - 1)) ? '0 : out_idx_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A request on the bit being cleared wins, so the channel re-arbitrates.
      pend_d = (pend_q & ~clr) | bus.req;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pend_q       <= '0;
         ptr_q        <= '0;
         mode_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         out_onehot_q <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         ptr_q        <= ptr_d;
         mode_q       <= mode_d;
         out_valid_q  <= out_valid_d;
         out_idx_q    <= out_idx_d;
         out_onehot_q <= out_onehot_d;
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + (W+1)'(pend_q[i]);
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_idx    = out_idx_q;
   assign bus.out_onehot = out_onehot_q;
   assign bus.pend_cnt   = cnt;
   assign bus.any        = (pend_q != '0);
   assign bus.dbg_state  = (state_q == S_GRANT);
endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: an N=8 and an N=5 instance share stimulus and are both
// compared every cycle against a behavioural model, plus directed grant-order checks.
module tb_prio_arb_enc;
   logic clk;
   logic rst_n;

   prio_arb_if #(.N(8)) bus8 ();
   prio_arb_if #(.N(5)) bus5 ();

   prio_arb_enc #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   prio_arb_enc #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] m_pend [2];
   int          m_ptr  [2];
   bit          m_busy [2];
   int          m_idx  [2];
   bit          m_gmode[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural reference: pending set, grant selection by mod-N scan.
   task automatic model_step(input int d, input logic [7:0] r, input logic m,
                             input logic rdy, input logic rn);
      int          n;
      logic [63:0] rq;
      logic [63:0] np;
      int          sel;
      bit          found;
      n  = (d == 0) ? 8 : 5;
      rq = {56'd0, r} & ((64'd1 << n) - 64'd1);
      if (!rn) begin
         m_pend[d] = '0; m_ptr[d] = 0; m_busy[d] = 0; m_idx[d] = 0; m_gmode[d] = 0;
         return;
      end
      np = m_pend[d];
      if (m_busy[d] && rdy) np[m_idx[d]] = 1'b0;
      np = np | rq;
      if (m_busy[d]) begin
         if (rdy) begin
            m_busy[d] = 0;
            if (m_gmode[d]) m_ptr[d] = (m_idx[d] + 1) % n;
         end
      end else if (m_pend[d] != 0) begin
         sel = 0;
         found = 0;
         if (!m) begin
            for (int i = 0; i < n; i++) if (m_pend[d][i]) sel = i;
         end else begin
            for (int k = 0; k < n; k++) begin
               int j;
               j = (m_ptr[d] + k) % n;
               if (!found && m_pend[d][j]) begin
                  found = 1;
                  sel = j;
               end
            end
         end
         m_busy[d]  = 1;
         m_idx[d]   = sel;
         m_gmode[d] = m;
      end
      m_pend[d] = np;
   endtask

   task automatic check_outputs();
      check("v8",   {63'd0, bus8.out_valid}, {63'd0, m_busy[0]});
      check("i8",   {61'd0, bus8.out_idx}, 64'(m_idx[0]));
      check("oh8",  {56'd0, bus8.out_onehot}, m_busy[0] ? (64'd1 << m_idx[0]) : 64'd0);
      check("cnt8", {60'd0, bus8.pend_cnt}, 64'($countones(m_pend[0])));
      check("any8", {63'd0, bus8.any}, {63'd0, (m_pend[0] != 0)});
      check("v5",   {63'd0, bus5.out_valid}, {63'd0, m_busy[1]});
      check("i5",   {61'd0, bus5.out_idx}, 64'(m_idx[1]));
      check("oh5",  {59'd0, bus5.out_onehot}, m_busy[1] ? (64'd1 << m_idx[1]) : 64'd0);
      check("cnt5", {60'd0, bus5.pend_cnt}, 64'($countones(m_pend[1])));
      check("any5", {63'd0, bus5.any}, {63'd0, (m_pend[1] != 0)});
   endtask

   // Drive one cycle of stimulus, advance the model at the edge, compare at negedge.
   task automatic cycle(input logic [7:0] r, input logic m, input logic rdy, input logic rn);
      rst_n          = rn;
      bus8.req       = r;
      bus8.mode      = m;
      bus8.out_ready = rdy;
      bus5.req       = r[4:0];
      bus5.mode      = m;
      bus5.out_ready = rdy;
      @(posedge clk);
      model_step(0, r, m, rdy, rn);
      model_step(1, r, m, rdy, rn);
      @(negedge clk);
      check_outputs();
   endtask

   // Wait (bounded) for a grant on instance d, check its index, then accept it.
   task automatic expect_grant(input string tag, input int d, input int exp, input logic m);
      logic       v;
      logic [2:0] idx;
      v = (d == 0) ? bus8.out_valid : bus5.out_valid;
      for (int t = 0; t < 8 && !v; t++) begin
         cycle(8'h00, m, 1'b1, 1'b1);
         v = (d == 0) ? bus8.out_valid : bus5.out_valid;
      end
      idx = (d == 0) ? bus8.out_idx : bus5.out_idx;
      check({tag, "_valid"}, {63'd0, v}, 64'd1);
      check(tag, {61'd0, idx}, 64'(exp));
      cycle(8'h00, m, 1'b1, 1'b1);
   endtask

   initial begin
      cycle(8'hFF, 1'b0, 1'b0, 1'b0);
      cycle(8'hFF, 1'b0, 1'b0, 1'b0);
      check("rst_valid", {63'd0, bus8.out_valid}, 64'd0);
      check("rst_idx",   {61'd0, bus8.out_idx}, 64'd0);
      check("rst_oh",    {56'd0, bus8.out_onehot}, 64'd0);
      check("rst_cnt",   {60'd0, bus8.pend_cnt}, 64'd0);
      check("rst_any",   {63'd0, bus8.any}, 64'd0);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);

      // Fixed priority: 0x94 -> 7, 4, 2 at two-cycle spacing.
      cycle(8'h94, 1'b0, 1'b1, 1'b1);
      check("fx_cnt", {60'd0, bus8.pend_cnt}, 64'd3);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      check("fx_g7", {56'd0, bus8.out_onehot}, 64'h80);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      check("fx_g4", {56'd0, bus8.out_onehot}, 64'h10);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      check("fx_g2", {56'd0, bus8.out_onehot}, 64'h04);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      check("fx_any", {63'd0, bus8.any}, 64'd0);

      // Round-robin order and wrap-around.
      cycle(8'hA4, 1'b1, 1'b1, 1'b1);
      expect_grant("rr_a", 0, 2, 1'b1);
      expect_grant("rr_b", 0, 5, 1'b1);
      expect_grant("rr_c", 0, 7, 1'b1);
      cycle(8'hA4, 1'b1, 1'b1, 1'b1);
      expect_grant("rr_d", 0, 2, 1'b1);
      expect_grant("rr_e", 0, 5, 1'b1);
      expect_grant("rr_f", 0, 7, 1'b1);
      cycle(8'h04, 1'b1, 1'b1, 1'b1);
      expect_grant("rr_g", 0, 2, 1'b1);
      cycle(8'h05, 1'b1, 1'b1, 1'b1);
      expect_grant("rr_wrap0", 0, 0, 1'b1);
      expect_grant("rr_wrap2", 0, 2, 1'b1);

      // Stall with a grant of 5 held while a new request accumulates.
      cycle(8'h20, 1'b0, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b0, 1'b1);
      for (int s = 0; s < 10; s++) begin
         cycle((s == 4) ? 8'h01 : 8'h00, 1'b0, 1'b0, 1'b1);
         check("stall_idx", {61'd0, bus8.out_idx}, 64'd5);
         check("stall_oh",  {56'd0, bus8.out_onehot}, 64'h20);
      end
      check("stall_cnt", {60'd0, bus8.pend_cnt}, 64'd2);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      expect_grant("stall_next", 0, 0, 1'b0);

      // Set beats clear on the handshake cycle.
      cycle(8'h08, 1'b0, 1'b1, 1'b1);
      cycle(8'h00, 1'b0, 1'b0, 1'b1);
      check("sbc_g3", {61'd0, bus8.out_idx}, 64'd3);
      cycle(8'h08, 1'b0, 1'b1, 1'b1);
      check("sbc_cnt", {60'd0, bus8.pend_cnt}, 64'd1);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      check("sbc_again", {56'd0, bus8.out_onehot}, 64'h08);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);

      // Reset during a held grant.
      cycle(8'h40, 1'b0, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b0, 1'b1);
      check("mid_valid", {63'd0, bus8.out_valid}, 64'd1);
      cycle(8'hFF, 1'b0, 1'b0, 1'b0);
      check("mid_rst_v",  {63'd0, bus8.out_valid}, 64'd0);
      check("mid_rst_oh", {56'd0, bus8.out_onehot}, 64'd0);
      check("mid_rst_ct", {60'd0, bus8.pend_cnt}, 64'd0);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);

      // N=5 round-robin: ptr=4 after granting 3, then 0x11 -> 4 then 0.
      cycle(8'h08, 1'b1, 1'b1, 1'b1);
      expect_grant("n5_g3", 1, 3, 1'b1);
      cycle(8'h11, 1'b1, 1'b1, 1'b1);
      expect_grant("n5_g4", 1, 4, 1'b1);
      expect_grant("n5_g0", 1, 0, 1'b1);

      // Randomized traffic, occasional resets.
      for (int c = 0; c < 400; c++) begin
         logic [7:0] r;
         r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         cycle(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 60) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
